ahb_lite_master: RTL
====================

// Module: ahb_lite_master
// PURPOSE
//  AHB-Lite initiator for the USB endpoint's AHB-Lite slave: turns single read/write commands from a
//  host-side controller/testbench into NONSEQ transfers on hsel/haddr/htrans/hsize/hwrite/hwdata.
//  Returns hrdata/hresp as one response per command, in order. Bus wait states via hready; two-cycle
//  ERROR response supported. Sits on the system side of the endpoint, opposite the slave.
// PARAMETERS
//  ADDR_WIDTH  7   haddr/cmd_addr width (endpoint register map is 7 bits)
//  DATA_WIDTH  32  hwdata/hrdata/cmd_wdata/rsp_rdata width
// PORTS
//  clk        in   1   system clock, rising edge
//  n_rst      in   1   async active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   command accepted on clk edge when cmd_valid&cmd_ready
//  cmd_write  in   1   1=write, 0=read
//  cmd_addr   in   AW  byte address
//  cmd_size   in   2   0=byte,1=half,2=word; 3 illegal
//  cmd_wdata  in   DW  write data
//  rsp_valid  out  1   one-cycle response pulse, no back-pressure
//  rsp_error  out  1   qualifies rsp_valid: bus ERROR, illegal command, or cancelled
//  rsp_rdata  out  DW  read data (0 for writes/errors)
//  hsel/haddr/htrans/hsize/hwrite  out  1/AW/2/2/1  AHB address-phase signals (registered)
//  hwdata     out  DW  AHB write data, valid in data phase
//  hrdata in DW; hready in 1; hresp in 1 (0=OKAY,1=ERROR)
// BEHAVIOUR
//  Interface: one clock clk; reset n_rst is asynchronous, active-low.
//  Reset: all outputs 0 (htrans=IDLE 2'b00, hsel=0, cmd_ready=0, rsp_valid=0); state IDLE; in-flight
//   command dropped, no response issued. cmd_ready=1 from first cycle after reset release.
//  States: IDLE, ADDR, DATA, ERR. All bus outputs registered.
//  IDLE: cmd_ready=1. Accept -> check legality: cmd_size=3 or addr misaligned for size (half: a[0]!=0;
//   word: a[1:0]!=0) -> no bus transfer, rsp_valid+rsp_error next cycle, stay IDLE. Else -> ADDR.
//  ADDR: hsel=1, htrans=NONSEQ(2'b10), haddr/hsize/hwrite from command. Held until edge with hready=1
//   -> DATA.
//  DATA: htrans=IDLE, hsel=0; hwdata=captured wdata (writes), 0 for reads. hold until hready=1.
//   hready=1,hresp=0 -> rsp_valid next cycle, rsp_rdata=hrdata (reads), ->IDLE.
//   hready=0,hresp=1 (1st error cycle) -> ERR. hready=1,hresp=1 without 1st cycle: treat as ERROR.
//  ERR: wait hready=1 (2nd error cycle) -> rsp_valid+rsp_error next cycle, ->IDLE.
//  Latency (no waits): accept edge T0; address phase T1; data phase T2; rsp_valid T3. Each wait
//   cycle adds 1. Throughput without pipelining: 1 command / 3 cycles.
//  Responses strictly in command order; exactly one rsp_valid per accepted command.
//  cmd_* sampled only on accept edge; changes afterward ignored.
// CONFIGURATION
//  AHB_MASTER_PIPELINE_EN defined: in ADDR, cmd_ready=hready; a command accepted on the edge that ends
//   the current address phase drives its NONSEQ address phase in the same cycle as the previous data
//   phase (back-to-back, 1 command/cycle with no waits). Illegal commands accepted there get error
//   response in order, no bus transfer. If previous data phase returns ERROR (1st cycle), the pending
//   address phase is replaced by htrans=IDLE in the 2nd error cycle; that command is cancelled and
//   reported rsp_valid+rsp_error after the erroring command's response.
//  Not defined: cmd_ready=0 outside IDLE; never overlaps transfers.
// TESTING
//  Word write addr 0x04 data 0xDEADBEEF, hready=1 -> T1 haddr=0x04 htrans=2'b10 hsize=2 hwrite=1; T2 hwdata=0xDEADBEEF; T3 rsp_valid, rsp_error=0
//  Byte read addr 0x41, slave hrdata=0x000000A5 with 2 wait states -> rsp_valid at T5, rsp_rdata=0xA5
//  Read addr 0x10, slave ERROR (hresp=1,hready=0 then hresp=1,hready=1) -> rsp_valid, rsp_error=1, rsp_rdata=0
//  Illegal: size=3 or half at 0x03 -> no hsel/htrans activity, rsp_error=1 one cycle after accept
//  Reset asserted during DATA wait -> outputs 0 immediately, no rsp_valid; next command completes normally
//  PIPELINE_EN: 4 back-to-back word writes 0x00..0x0C, hready=1 -> NONSEQ on 4 consecutive cycles, 4 OKAY rsps in order; ERROR on 1st -> 2nd cancelled (rsp_error=1)

Source files
------------

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-command AHB-Lite initiator with in-order responses
// Define AHB_MASTER_PIPELINE_EN to overlap the next address phase with the current data phase.
module ahb_lite_master #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [1:0]            cmd_size,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_error,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  hsel,
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic [1:0]            htrans,
   output logic [1:0]            hsize,
   output logic                  hwrite,
   output logic [DATA_WIDTH-1:0] hwdata,
   input  logic [DATA_WIDTH-1:0] hrdata,
   input  logic                  hready,
   input  logic                  hresp
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
   state_t state, state_n;
   logic live, a_vld, a_bad, d_bad, d_write;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic bad_cmd, accept, imm_err, take, a_mv, d_fin, d_err1, hsel_n;
`ifdef AHB_MASTER_PIPELINE_EN
   assign cmd_ready = live & (state != ERR) & ~((state == DATA) & hresp) & (~a_vld | hready);
`else
   assign cmd_ready = live & (state == IDLE);
`endif
   // a_bad marks an address slot that never reaches the bus (illegal or cancelled command)
   always_comb begin
      bad_cmd = (cmd_size == 2'd3) | ((cmd_size == 2'd1) & cmd_addr[0]) | ((cmd_size == 2'd2) & |cmd_addr[1:0]);
      accept  = cmd_valid & cmd_ready;
      imm_err = accept & bad_cmd & (state == IDLE);
      take    = accept & ~imm_err;
      a_mv    = a_vld & hready;
      d_fin   = ((state == DATA) | (state == ERR)) & hready;
      d_err1  = (state == DATA) & ~hready & hresp & ~d_bad;
      hsel_n  = take ? ~bad_cmd : hsel & ~a_mv & ~d_err1;
      state_n = a_mv ? DATA : (d_fin | (state == IDLE)) ? (take ? ADDR : IDLE) : d_err1 ? ERR : state;
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         live      <= 1'b0;
         a_vld     <= 1'b0;
         a_bad     <= 1'b0;
         d_bad     <= 1'b0;
         d_write   <= 1'b0;
         a_wdata   <= '0;
         rsp_valid <= 1'b0;
         rsp_error <= 1'b0;
         rsp_rdata <= '0;
         hsel      <= 1'b0;
         haddr     <= '0;
         htrans    <= 2'b00;
         hsize     <= 2'b00;
         hwrite    <= 1'b0;
         hwdata    <= '0;
      end else begin
         state     <= state_n;
         live      <= 1'b1;
         a_vld     <= take | (a_vld & ~a_mv);
         a_bad     <= take ? bad_cmd : a_bad | d_err1;
         hsel      <= hsel_n;
         htrans    <= {hsel_n, 1'b0};
         if (take) begin
            haddr   <= cmd_addr;
            hsize   <= cmd_size;
            hwrite  <= cmd_write;
            a_wdata <= cmd_wdata;
         end
         if (a_mv) begin
            d_bad   <= a_bad;
            d_write <= hwrite;
         end
         hwdata    <= a_mv ? ((hwrite & ~a_bad) ? a_wdata : '0) : d_fin ? '0 : hwdata;
         rsp_valid <= imm_err | d_fin;
         rsp_error <= imm_err | (d_fin & ((state == ERR) | d_bad | hresp));
         rsp_rdata <= ((state == DATA) & hready & ~hresp & ~d_bad & ~d_write) ? hrdata : '0;
      end
   end
endmodule
